// File: rtl/pmem_tag_gen_if.sv
// Bundle between the packet memory group and the tag generator: packet streams, tag return, table config, stats.
// master = packet memory group / host side, slave = tag generator.
interface pmem_tag_gen_if #(
   parameter int NPORTS        = 4,
   parameter int TABLE_ENTRIES = 16
);
   localparam int AW = $clog2(TABLE_ENTRIES);

   logic [64*NPORTS-1:0] packetout_data;
   logic [NPORTS-1:0]    packetout_valid;
   logic [NPORTS-1:0]    packetout_sop;
   logic [NPORTS-1:0]    packetout_eop;
   logic [6*NPORTS-1:0]  packetout_channel;
   logic [NPORTS-1:0]    packetout_ready;

   logic [NPORTS+5:0]    tagout_data;
   logic                 tagout_valid;
   logic                 tagout_ready;

   logic                 cfg_wr_en;
   logic [AW-1:0]        cfg_addr;
   logic [47:0]          cfg_mac;
   logic [NPORTS-1:0]    cfg_mask;
   logic                 cfg_entry_valid;

   logic [15:0]          stat_miss;
   logic [15:0]          stat_proto_err;

   modport master (
      output packetout_data, packetout_valid, packetout_sop, packetout_eop, packetout_channel,
      input  packetout_ready,
      input  tagout_data, tagout_valid,
      output tagout_ready,
      output cfg_wr_en, cfg_addr, cfg_mac, cfg_mask, cfg_entry_valid,
      input  stat_miss, stat_proto_err
   );

   modport slave (
      input  packetout_data, packetout_valid, packetout_sop, packetout_eop, packetout_channel,
      output packetout_ready,
      output tagout_data, tagout_valid,
      input  tagout_ready,
      input  cfg_wr_en, cfg_addr, cfg_mac, cfg_mask, cfg_entry_valid,
      output stat_miss, stat_proto_err
   );
endinterface

// File: rtl/pmem_tag_gen.sv
// Per-packet tag generator: dest MAC -> egress mask via 16-entry table, one {mask,channel} tag per packet.
// Tag written 2 cycles after sop; ports hold (ready=0) until granted, grants stop while the tag FIFO could overflow.
module pmem_tag_gen #(
   parameter int NPORTS        = 4,
   parameter int TABLE_ENTRIES = 16,
   parameter int FIFO_DEPTH    = 8
) (
   input logic           clock,
   input logic           reset,
   pmem_tag_gen_if.slave bus
);
   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = $clog2(NPORTS + 1);
   localparam int TW = NPORTS + 6;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t            state_q    [NPORTS];
   state_t            state_d    [NPORTS];
   logic [47:0]       cap_mac_q  [NPORTS];
   logic [47:0]       cap_mac_d  [NPORTS];
   logic [5:0]        cap_chan_q [NPORTS];
   logic [5:0]        cap_chan_d [NPORTS];
   logic [NPORTS-1:0] cap_eop_q, cap_eop_d;

   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gnt_idx, rr_idx;
   logic              gnt_vld, can_grant;

   logic              lk_vld_q, lk_vld_d;
   logic [47:0]       lk_mac_q, lk_mac_d;
   logic [5:0]        lk_chan_q, lk_chan_d;
   logic [PW-1:0]     lk_port_q, lk_port_d;
   logic              lk_hit, lk_miss;
   logic [NPORTS-1:0] lk_hit_mask, lk_ing, lk_mask;

   logic [TABLE_ENTRIES-1:0] tbl_vld_q, tbl_vld_d;
   logic [47:0]       tbl_mac_q  [TABLE_ENTRIES];
   logic [47:0]       tbl_mac_d  [TABLE_ENTRIES];
   logic [NPORTS-1:0] tbl_mask_q [TABLE_ENTRIES];
   logic [NPORTS-1:0] tbl_mask_d [TABLE_ENTRIES];

   logic [TW-1:0]     mem_q [FIFO_DEPTH];
   logic [TW-1:0]     mem_d [FIFO_DEPTH];
   logic [FW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FW:0]       count_q, count_d;
   logic              push, pop;

   logic [15:0]       stat_miss_q, stat_miss_d, stat_err_q, stat_err_d;
   logic [16:0]       err_sum;
   logic [EW-1:0]     err_cnt;
   logic [63:0]       beat;
   logic [NPORTS-1:0] rdy;
   logic              unused_lo;

   // Round-robin from ptr_q; NPORTS is a power of two so the index add wraps naturally.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      rr_idx    = '0;
      ptr_d     = ptr_q;
      can_grant = ({1'b0, count_q} + {{(FW+1){1'b0}}, lk_vld_q}) < (FW+2)'(FIFO_DEPTH);
      for (int i = 0; i < NPORTS; i++) begin
         rr_idx = ptr_q + PW'(i);
         if (can_grant && !gnt_vld && state_q[rr_idx] == S_HOLD) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_idx;
         end
      end
      if (gnt_vld) ptr_d = gnt_idx + PW'(1);
   end

   always_comb begin
      err_cnt   = '0;
      beat      = '0;
      rdy       = '0;
      cap_eop_d = cap_eop_q;
      unused_lo = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
         state_d[p]    = state_q[p];
         cap_mac_d[p]  = cap_mac_q[p];
         cap_chan_d[p] = cap_chan_q[p];
         beat          = bus.packetout_data[64*p +: 64];
         unused_lo     = unused_lo ^ (^beat[15:0]);
         rdy[p]        = reset && (state_q[p] != S_HOLD);
         case (state_q[p])
            S_IDLE: begin
               if (bus.packetout_valid[p]) begin
                  if (bus.packetout_sop[p]) begin
                     cap_mac_d[p]  = beat[63:16];
                     cap_chan_d[p] = bus.packetout_channel[6*p +: 6];
                     cap_eop_d[p]  = bus.packetout_eop[p];
                     state_d[p]    = S_HOLD;
                  end else begin
                     err_cnt = err_cnt + EW'(1);
                  end
               end
            end
            S_HOLD: begin
               if (gnt_vld && gnt_idx == PW'(p)) state_d[p] = cap_eop_q[p] ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
               if (bus.packetout_valid[p]) begin
                  if (bus.packetout_sop[p]) err_cnt = err_cnt + EW'(1);
                  if (bus.packetout_eop[p]) state_d[p] = S_IDLE;
               end
            end
            default: state_d[p] = S_IDLE;
         endcase
      end
   end

   assign bus.packetout_ready = rdy;

   always_comb begin
      lk_vld_d  = gnt_vld;
      lk_mac_d  = cap_mac_q[gnt_idx];
      lk_chan_d = cap_chan_q[gnt_idx];
      lk_port_d = gnt_idx;
   end

   // Descending scan so the lowest-index matching entry wins.
   always_comb begin
      lk_hit      = 1'b0;
      lk_hit_mask = '0;
      for (int e = TABLE_ENTRIES - 1; e >= 0; e--) begin
         if (tbl_vld_q[e] && tbl_mac_q[e] == lk_mac_q) begin
            lk_hit      = 1'b1;
            lk_hit_mask = tbl_mask_q[e];
         end
      end
      lk_ing            = '0;
      lk_ing[lk_port_q] = 1'b1;
      lk_mask = ((lk_mac_q[40] || !lk_hit) ? {NPORTS{1'b1}} : lk_hit_mask) & ~lk_ing;
      lk_miss = lk_vld_q && !lk_mac_q[40] && !lk_hit;
   end

   always_comb begin
      tbl_vld_d  = tbl_vld_q;
      tbl_mac_d  = tbl_mac_q;
      tbl_mask_d = tbl_mask_q;
      if (bus.cfg_wr_en) begin
         tbl_vld_d[bus.cfg_addr]  = bus.cfg_entry_valid;
         tbl_mac_d[bus.cfg_addr]  = bus.cfg_mac;
         tbl_mask_d[bus.cfg_addr] = bus.cfg_mask;
      end
   end

   always_comb begin
      push     = lk_vld_q;
      pop      = (count_q != '0) && bus.tagout_ready;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {lk_mask, lk_chan_q};
         wr_ptr_d        = wr_ptr_q + FW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + FW'(1);
      if (push && !pop) count_d = count_q + (FW+1)'(1);
      else if (!push && pop) count_d = count_q - (FW+1)'(1);
   end

   assign bus.tagout_valid = (count_q != '0);
   assign bus.tagout_data  = bus.tagout_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      stat_miss_d = stat_miss_q;
      if (lk_miss && stat_miss_q != 16'hFFFF) stat_miss_d = stat_miss_q + 16'd1;
      err_sum    = {1'b0, stat_err_q} + 17'(err_cnt);
      stat_err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   assign bus.stat_miss      = stat_miss_q;
   assign bus.stat_proto_err = stat_err_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int p = 0; p < NPORTS; p++) state_q[p] <= S_IDLE;
         ptr_q       <= '0;
         lk_vld_q    <= 1'b0;
         tbl_vld_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         stat_miss_q <= '0;
         stat_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lk_vld_q    <= lk_vld_d;
         tbl_vld_q   <= tbl_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         stat_miss_q <= stat_miss_d;
         stat_err_q  <= stat_err_d;
      end
   end

   // Payload registers are qualified by the control state above, so they need no reset.
   always_ff @(posedge clock) begin
      cap_mac_q  <= cap_mac_d;
      cap_chan_q <= cap_chan_d;
      cap_eop_q  <= cap_eop_d;
      lk_mac_q   <= lk_mac_d;
      lk_chan_q  <= lk_chan_d;
      lk_port_q  <= lk_port_d;
      tbl_mac_q  <= tbl_mac_d;
      tbl_mask_q <= tbl_mask_d;
      mem_q      <= mem_d;
   end
endmodule

// File: tb/tb_pmem_tag_gen.sv
// Directed bench for pmem_tag_gen: lookup, flood, round-robin, backpressure, proto errors and mid-packet reset.
module tb_pmem_tag_gen;
   localparam logic [47:0] MAC_A = 48'h001122334455;
   localparam logic [47:0] MAC_B = 48'h00AABBCCDDEE;
   localparam logic [47:0] MAC_C = 48'h001234567890;
   localparam logic [47:0] MAC_U = 48'h020000000001;
   localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pmem_tag_gen_if #(.NPORTS(4), .TABLE_ENTRIES(16)) bus ();

   pmem_tag_gen #(.NPORTS(4), .TABLE_ENTRIES(16), .FIFO_DEPTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      bus.packetout_valid = '0;
      bus.packetout_sop   = '0;
      bus.packetout_eop   = '0;
   endtask

   task automatic beat(input int p, input logic s, input logic e, input logic [47:0] mac, input logic [5:0] ch);
      bus.packetout_valid[p]         = 1'b1;
      bus.packetout_sop[p]           = s;
      bus.packetout_eop[p]           = e;
      bus.packetout_data[64*p +: 64] = {mac, 16'h0000};
      bus.packetout_channel[6*p +: 6] = ch;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [47:0] mac, input logic [3:0] m, input logic v);
      bus.cfg_wr_en = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_mac = mac;
      bus.cfg_mask = m;
      bus.cfg_entry_valid = v;
      tick();
      bus.cfg_wr_en = 1'b0;
   endtask

   // Broadcast from port p floods every port except the ingress.
   function automatic logic [9:0] bc_tag(input int p, input int ch);
      logic [3:0] m;
      m = 4'hF & ~(4'b0001 << p);
      return {m, 6'(ch)};
   endfunction

   // Single-beat broadcast on each selected port (channel 10+p); ord lists expected grant order, 2 bits per slot.
   task automatic burst(input logic [3:0] ports, input logic [7:0] ord, input int n);
      logic [3:0] nr;
      int pp;
      nr = ~ports;
      clr();
      for (int p = 0; p < 4; p++) if (ports[p]) beat(p, 1'b1, 1'b1, BCAST, 6'(10 + p));
      tick();
      chk("burst_hold_rdy", bus.packetout_ready, nr);
      clr();
      tick();
      for (int i = 0; i < n; i++) begin
         tick();
         pp = int'(ord[2*i +: 2]);
         chk("burst_tag_vld", bus.tagout_valid, 1);
         chk("burst_tag", bus.tagout_data, bc_tag(pp, 10 + pp));
      end
      tick();
      chk("burst_empty", bus.tagout_valid, 0);
   endtask

   initial begin
      reset = 1'b0;
      bus.packetout_data = '0;
      bus.packetout_channel = '0;
      clr();
      bus.tagout_ready = 1'b1;
      bus.cfg_wr_en = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_mac = '0;
      bus.cfg_mask = '0;
      bus.cfg_entry_valid = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_ready", bus.packetout_ready, 4'b0000);
      chk("rst_tvalid", bus.tagout_valid, 0);
      chk("rst_tdata", bus.tagout_data, 0);
      chk("rst_miss", bus.stat_miss, 0);
      chk("rst_perr", bus.stat_proto_err, 0);
      reset = 1'b1;
      tick();
      chk("post_rst_ready", bus.packetout_ready, 4'b1111);

      // Unicast hit, 4-beat packet on port 0
      cfg_write(4'd0, MAC_A, 4'b1000, 1'b1);
      beat(0, 1'b1, 1'b0, MAC_A, 6'd5);
      tick();
      chk("hit_hold_rdy", bus.packetout_ready, 4'b1110);
      clr();
      tick();
      chk("hit_drain_rdy", bus.packetout_ready, 4'b1111);
      chk("hit_not_yet", bus.tagout_valid, 0);
      beat(0, 1'b0, 1'b0, 48'h0, 6'd0);
      tick();
      chk("hit_tvalid", bus.tagout_valid, 1);
      chk("hit_tag", bus.tagout_data, 10'b1000_000101);
      beat(0, 1'b0, 1'b0, 48'h0, 6'd0);
      tick();
      chk("hit_one_cycle", bus.tagout_valid, 0);
      beat(0, 1'b0, 1'b1, 48'h0, 6'd0);
      tick();
      clr();
      chk("hit_miss0", bus.stat_miss, 0);
      chk("hit_perr0", bus.stat_proto_err, 0);

      // Unknown unicast on port 1 and broadcast on port 2, same cycle
      beat(1, 1'b1, 1'b1, MAC_U, 6'd9);
      beat(2, 1'b1, 1'b1, BCAST, 6'd0);
      tick();
      chk("uc_bc_rdy", bus.packetout_ready, 4'b1001);
      clr();
      tick();
      tick();
      chk("miss_tag", bus.tagout_data, 10'b1101_001001);
      tick();
      chk("bcast_tag", bus.tagout_data, 10'b1011_000000);
      chk("miss_cnt1", bus.stat_miss, 1);
      tick();
      chk("uc_bc_empty", bus.tagout_valid, 0);

      // Entry mapping to the ingress port only -> discard tag with mask 0
      cfg_write(4'd1, MAC_B, 4'b1000, 1'b1);
      beat(3, 1'b1, 1'b1, MAC_B, 6'd7);
      tick();
      clr();
      tick();
      tick();
      chk("zero_mask_vld", bus.tagout_valid, 1);
      chk("zero_mask_tag", bus.tagout_data, 10'b0000_000111);
      tick();
      chk("zero_mask_nomiss", bus.stat_miss, 1);

      // Round-robin bursts
      burst(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4);
      burst(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4);
      burst(4'b0010, {2'd0, 2'd0, 2'd0, 2'd1}, 1);
      burst(4'b1001, {2'd0, 2'd0, 2'd0, 2'd3}, 2);

      // Table write in the same cycle as the lookup: old contents apply
      beat(0, 1'b1, 1'b1, MAC_C, 6'd4);
      tick();
      clr();
      tick();
      bus.cfg_wr_en = 1'b1;
      bus.cfg_addr = 4'd2;
      bus.cfg_mac = MAC_C;
      bus.cfg_mask = 4'b0010;
      bus.cfg_entry_valid = 1'b1;
      tick();
      bus.cfg_wr_en = 1'b0;
      chk("wr_lookup_old", bus.tagout_data, 10'b1110_000100);
      tick();
      chk("wr_lookup_miss", bus.stat_miss, 2);
      beat(0, 1'b1, 1'b1, MAC_C, 6'd4);
      tick();
      clr();
      tick();
      tick();
      chk("wr_lookup_new", bus.tagout_data, 10'b0010_000100);
      tick();

      // Body beat in IDLE is consumed and counted
      beat(2, 1'b0, 1'b0, MAC_A, 6'd1);
      chk("perr_rdy", bus.packetout_ready[2], 1);
      tick();
      clr();
      chk("perr_cnt", bus.stat_proto_err, 1);
      chk("perr_state", bus.packetout_ready, 4'b1111);
      tick();
      chk("perr_no_tag", bus.tagout_valid, 0);

      // Backpressure: 10 packets, 8 buffered, 2 ports left holding
      bus.tagout_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         clr();
         beat(i % 4, 1'b1, 1'b1, BCAST, 6'(i));
         tick();
      end
      clr();
      tick();
      tick();
      chk("bp_hold_rdy", bus.packetout_ready, 4'b1100);
      chk("bp_tvalid", bus.tagout_valid, 1);
      chk("bp_head", bus.tagout_data, bc_tag(0, 0));
      tick(); tick(); tick();
      chk("bp_head_stable", bus.tagout_data, bc_tag(0, 0));
      chk("bp_still_hold", bus.packetout_ready, 4'b1100);
      bus.tagout_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_drain_tag", bus.tagout_data, bc_tag(i % 4, i));
         tick();
      end
      chk("bp_drained", bus.tagout_valid, 0);
      chk("bp_rdy_all", bus.packetout_ready, 4'b1111);

      // Reset with port 3 mid-DRAIN and 3 tags queued
      bus.tagout_ready = 1'b0;
      beat(0, 1'b1, 1'b1, BCAST, 6'd1);
      beat(1, 1'b1, 1'b1, BCAST, 6'd2);
      beat(3, 1'b1, 1'b0, BCAST, 6'd3);
      tick();
      clr();
      tick(); tick(); tick(); tick();
      chk("mid_tvalid", bus.tagout_valid, 1);
      chk("mid_head", bus.tagout_data, bc_tag(3, 3));
      chk("mid_rdy", bus.packetout_ready, 4'b1111);
      beat(3, 1'b0, 1'b0, 48'h0, 6'd0);
      tick();
      clr();
      reset = 1'b0;
      tick();
      chk("mrst_tvalid", bus.tagout_valid, 0);
      chk("mrst_tdata", bus.tagout_data, 0);
      chk("mrst_rdy", bus.packetout_ready, 4'b0000);
      chk("mrst_miss", bus.stat_miss, 0);
      chk("mrst_perr", bus.stat_proto_err, 0);
      reset = 1'b1;
      bus.tagout_ready = 1'b1;
      tick();
      chk("mrst_rel_rdy", bus.packetout_ready, 4'b1111);
      chk("mrst_rel_tvalid", bus.tagout_valid, 0);
      beat(0, 1'b1, 1'b1, MAC_A, 6'd3);
      tick();
      clr();
      tick();
      chk("mrst_no_stale", bus.tagout_valid, 0);
      tick();
      chk("mrst_fresh_tag", bus.tagout_data, 10'b1110_000011);
      tick();
      chk("mrst_table_clr", bus.stat_miss, 1);
      chk("mrst_done", bus.tagout_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
